// File: rtl/dii_ring_node.sv
// Debug-ring stop serving PORTS local DII endpoints at consecutive module IDs.
// Ring packets are delivered locally or forwarded; egress is a packet-atomic round-robin.
module dii_ring_node #(
  parameter int PORTS     = 2,
  parameter int BASE_ID   = 0,
  parameter int BUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           ring_in_data,
  input  logic                  ring_in_first,
  input  logic                  ring_in_last,
  input  logic                  ring_in_valid,
  output logic                  ring_in_ready,
  output logic [15:0]           ring_out_data,
  output logic                  ring_out_first,
  output logic                  ring_out_last,
  output logic                  ring_out_valid,
  input  logic                  ring_out_ready,
  input  logic [PORTS*16-1:0]   local_in_data,
  input  logic [PORTS-1:0]      local_in_first,
  input  logic [PORTS-1:0]      local_in_last,
  input  logic [PORTS-1:0]      local_in_valid,
  output logic [PORTS-1:0]      local_in_ready,
  output logic [PORTS*16-1:0]   local_out_data,
  output logic [PORTS-1:0]      local_out_first,
  output logic [PORTS-1:0]      local_out_last,
  output logic [PORTS-1:0]      local_out_valid,
  input  logic [PORTS-1:0]      local_out_ready
);

  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int GW  = $clog2(PORTS + 1);
  localparam int FWD = PORTS;

  typedef enum logic {IDLE, ROUTED} route_state_t;
  typedef struct packed {
    logic        first;
    logic        last;
    logic [15:0] data;
  } flit_t;

  // ---------------- ingress FIFO ----------------
  flit_t       mem [BUF_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  flit_t       head;

  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign head          = mem[rd_ptr[AW-1:0]];
  assign ring_in_ready = rst && !full;
  assign push          = ring_in_valid && ring_in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ring_in_first, ring_in_last, ring_in_data};
  end

  // ---------------- routing ----------------
  route_state_t    state;
  logic            route_local;
  logic [GW-1:0]   route_idx;
  logic [9:0]      calc_idx;
  logic            calc_local, eff_local, orphan, active, fwd_valid, fwd_ready, local_hs;
  logic [GW-1:0]   eff_idx;

  assign calc_idx   = head.data[9:0] - 10'(BASE_ID);
  assign calc_local = calc_idx < 10'(PORTS);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    eff_local       = route_local;
    eff_idx         = route_idx;
    local_out_valid = '0;
    if (state == IDLE) begin
      eff_local = calc_local;
      eff_idx   = calc_idx[GW-1:0];
    end
    orphan    = !empty && (state == IDLE) && !head.first;
    active    = !empty && !orphan;
    fwd_valid = active && !eff_local;
    for (int p = 0; p < PORTS; p++)
      local_out_valid[p] = rst && active && eff_local && (eff_idx == GW'(p));
    local_hs = |(local_out_valid & local_out_ready);
    pop      = orphan || local_hs || (fwd_valid && fwd_ready);
  end

  assign local_out_data  = {PORTS{head.data}};
  assign local_out_first = {PORTS{head.first}};
  assign local_out_last  = {PORTS{head.last}};

  // The route is latched on the first flit and held until the last flit leaves the head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      route_local <= 1'b0;
      route_idx   <= '0;
    end else if (active) begin
      if (state == IDLE) begin
        route_local <= calc_local;
        route_idx   <= calc_idx[GW-1:0];
      end
      state <= (pop && head.last) ? IDLE : ROUTED;
    end
  end

  // ---------------- egress arbiter ----------------
  flit_t           req [PORTS+1];
  logic [PORTS:0]  req_valid;
  logic            busy, sel_ok, load_en, xfer, out_valid;
  logic [GW-1:0]   grant, last_grant, sel;
  int              cand;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      req[p]       = {local_in_first[p], local_in_last[p], local_in_data[16*p +: 16]};
      req_valid[p] = local_in_valid[p];
    end
    req[FWD]       = head;
    req_valid[FWD] = fwd_valid;
  end

  // Round-robin search starts just after the previous winner, wrapping FORWARD -> local 0.
  always_comb begin
    sel    = grant;
    sel_ok = busy;
    cand   = 0;
    if (!busy) begin
      for (int k = 1; k <= PORTS + 1; k++) begin
        cand = (int'(last_grant) + k) % (PORTS + 1);
        if (!sel_ok && req_valid[cand] && req[cand].first) begin
          sel    = GW'(cand);
          sel_ok = 1'b1;
        end
      end
    end
  end

  assign load_en   = !out_valid || ring_out_ready;
  assign xfer      = rst && sel_ok && req_valid[sel] && load_en;
  assign fwd_ready = rst && sel_ok && (sel == GW'(FWD)) && load_en;

  // A stray continuation flit from a non-granted local input is swallowed to avoid deadlock.
  always_comb begin
    local_in_ready = '0;
    for (int p = 0; p < PORTS; p++)
      local_in_ready[p] = rst && ((sel_ok && (sel == GW'(p)) && load_en) ||
                                  (local_in_valid[p] && !local_in_first[p] &&
                                   !(busy && (grant == GW'(p)))));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      grant      <= '0;
      last_grant <= GW'(FWD);
    end else begin
      if (load_en) out_valid <= xfer;
      if (xfer) begin
        busy       <= !req[sel].last;
        grant      <= sel;
        last_grant <= sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) {ring_out_first, ring_out_last, ring_out_data} <= req[sel];
  end

  assign ring_out_valid = out_valid;

endmodule

// File: tb/tb_dii_ring_node.sv
// Directed scoreboard bench for dii_ring_node (PORTS=3, BASE_ID=5, BUF_DEPTH=4).
module tb_dii_ring_node;

  localparam int PORTS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   ring_in_data, ring_out_data;
  logic          ring_in_first, ring_in_last, ring_in_valid, ring_in_ready;
  logic          ring_out_first, ring_out_last, ring_out_valid, ring_out_ready;
  logic [47:0]   local_in_data, local_out_data;
  logic [2:0]    local_in_first, local_in_last, local_in_valid, local_in_ready;
  logic [2:0]    local_out_first, local_out_last, local_out_valid, local_out_ready;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [17:0]   rq[$], lq0[$], lq1[$], lq2[$];
  logic          m_routed = 1'b0;
  logic          m_local  = 1'b0;
  logic [1:0]    m_port   = 2'd0;

  always #5 clk = ~clk;

  dii_ring_node #(.PORTS(3), .BASE_ID(5), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ring_in_data(ring_in_data), .ring_in_first(ring_in_first), .ring_in_last(ring_in_last),
    .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
    .ring_out_data(ring_out_data), .ring_out_first(ring_out_first), .ring_out_last(ring_out_last),
    .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
    .local_in_data(local_in_data), .local_in_first(local_in_first), .local_in_last(local_in_last),
    .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
    .local_out_data(local_out_data), .local_out_first(local_out_first), .local_out_last(local_out_last),
    .local_out_valid(local_out_valid), .local_out_ready(local_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference routing model: decides where an accepted ring flit must come out.
  task automatic model_ring(input logic [15:0] d, input logic f, input logic l);
    logic [9:0] idx;
    if (!m_routed) begin
      if (!f) return;
      idx     = d[9:0] - 10'd5;
      m_local = (idx < 10'd3);
      m_port  = idx[1:0];
    end
    m_routed = !l;
    if (!m_local) rq.push_back({f, l, d});
    else case (m_port)
      2'd0:    lq0.push_back({f, l, d});
      2'd1:    lq1.push_back({f, l, d});
      default: lq2.push_back({f, l, d});
    endcase
  endtask

  task automatic ring_flit(input logic [15:0] d, input logic f, input logic l);
    int   cnt = 0;
    logic acc = 1'b0;
    ring_in_data = d; ring_in_first = f; ring_in_last = l; ring_in_valid = 1'b1;
    while (!acc && cnt < 100) begin
      @(negedge clk); acc = ring_in_ready;
      @(posedge clk); #1; cnt++;
    end
    ring_in_valid = 1'b0;
    if (!acc) check("ring_in_timeout", 32'(acc), 32'd1);
    else model_ring(d, f, l);
  endtask

  task automatic local_flit(input int p, input logic [15:0] d, input logic f, input logic l);
    int   cnt = 0;
    logic acc = 1'b0;
    local_in_valid = '0;
    local_in_valid[p] = 1'b1; local_in_first[p] = f; local_in_last[p] = l;
    local_in_data[16*p +: 16] = d;
    while (!acc && cnt < 100) begin
      @(negedge clk); acc = local_in_ready[p];
      @(posedge clk); #1; cnt++;
    end
    local_in_valid = '0;
    if (!acc) check("local_in_timeout", 32'(acc), 32'd1);
    else rq.push_back({f, l, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: every handshake on an egress channel is popped against the scoreboard.
  always @(negedge clk) begin
    logic [17:0] got, exp;
    logic        have;
    if (rst) begin
      if (ring_out_valid && ring_out_ready) begin
        got = {ring_out_first, ring_out_last, ring_out_data};
        check("ring_out_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          exp = rq.pop_front();
          check("ring_out_flit", 32'(got), 32'(exp));
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        if (local_out_valid[p] && local_out_ready[p]) begin
          got  = {local_out_first[p], local_out_last[p], local_out_data[16*p +: 16]};
          have = 1'b0;
          exp  = '0;
          case (p)
            0:       if (lq0.size() != 0) begin exp = lq0.pop_front(); have = 1'b1; end
            1:       if (lq1.size() != 0) begin exp = lq1.pop_front(); have = 1'b1; end
            default: if (lq2.size() != 0) begin exp = lq2.pop_front(); have = 1'b1; end
          endcase
          check($sformatf("local_out%0d_expected", p), 32'(have), 32'd1);
          if (have) check($sformatf("local_out%0d_flit", p), 32'(got), 32'(exp));
        end
      end
    end
  end

  initial begin
    int   c, fptr, lp0, lp2;
    logic acc, a0, a2;

    rst = 1'b0;
    ring_in_data = '0; ring_in_first = 1'b0; ring_in_last = 1'b0; ring_in_valid = 1'b0;
    ring_out_ready = 1'b1;
    local_in_data = '0; local_in_first = '0; local_in_last = '0; local_in_valid = '0;
    local_out_ready = 3'b111;

    // Reset state
    idle(2);
    check("rst_ring_out_valid", 32'(ring_out_valid), 32'd0);
    check("rst_local_out_valid", 32'(local_out_valid), 32'd0);
    check("rst_ring_in_ready", 32'(ring_in_ready), 32'd0);
    check("rst_local_in_ready", 32'(local_in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_ring_in_ready", 32'(ring_in_ready), 32'd1);

    // Local delivery: dest 6 -> port 1, one cycle after each accept
    ring_flit(16'h0006, 1'b1, 1'b0);
    check("local_lat_f0", 32'(local_out_valid), 32'b010);
    ring_flit(16'hA001, 1'b0, 1'b0);
    check("local_lat_f1", 32'(local_out_valid), 32'b010);
    ring_flit(16'hA002, 1'b0, 1'b1);
    check("local_lat_f2", 32'(local_out_valid), 32'b010);
    idle(2);

    // Forwarding: dest 8 (above range) and dest 4 (below base, wraps)
    ring_flit(16'h0008, 1'b1, 1'b1);
    check("fwd8_not_early", 32'(ring_out_valid), 32'd0);
    idle(1);
    check("fwd8_lat", 32'({ring_out_valid, ring_out_data}), 32'({1'b1, 16'h0008}));
    ring_flit(16'h0004, 1'b1, 1'b1);
    check("fwd4_not_early", 32'(ring_out_valid), 32'd0);
    idle(1);
    check("fwd4_lat", 32'({ring_out_valid, ring_out_data}), 32'({1'b1, 16'h0004}));
    idle(2);

    // Local input to ring: one cycle after acceptance
    local_flit(1, 16'h4321, 1'b1, 1'b1);
    check("local_in_lat", 32'({ring_out_valid, ring_out_data}), 32'({1'b1, 16'h4321}));
    // Continuation flit with no grant is swallowed
    local_in_valid = 3'b010; local_in_first = 3'b000; local_in_data = 48'h0000_DEAD_0000;
    #1;
    check("local_drop_ready", 32'(local_in_ready[1]), 32'd1);
    local_in_valid = '0;
    idle(2);

    // Orphan and 1-flit boundary
    ring_flit(16'h0006, 1'b0, 1'b1);
    check("orphan_no_local", 32'(local_out_valid), 32'd0);
    idle(1);
    check("orphan_no_ring", 32'(ring_out_valid), 32'd0);
    ring_flit(16'h0005, 1'b1, 1'b1);
    check("one_flit_port0", 32'(local_out_valid), 32'b001);
    ring_flit(16'h0007, 1'b0, 1'b0);
    check("idle_after_one_flit", 32'(local_out_valid), 32'd0);
    idle(2);

    // Backpressure: 6-flit forward packet with ring_out stalled for 10 cycles
    ring_out_ready = 1'b0;
    fptr = 0; c = 0;
    while ((fptr < 6 || rq.size() != 0) && c < 100) begin
      if (fptr < 6) begin
        ring_in_valid = 1'b1;
        ring_in_first = (fptr == 0);
        ring_in_last  = (fptr == 5);
        ring_in_data  = (fptr == 0) ? 16'h0123 : (16'hB000 | 16'(fptr));
      end else ring_in_valid = 1'b0;
      @(negedge clk); acc = ring_in_valid && ring_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        model_ring(ring_in_data, ring_in_first, ring_in_last);
        fptr++;
      end
      if (c == 9) begin
        check("bp_ring_in_ready", 32'(ring_in_ready), 32'd0);
        check("bp_accepted", 32'(fptr), 32'd5);
        check("bp_hold", 32'({ring_out_valid, ring_out_data}), 32'({1'b1, 16'h0123}));
        ring_out_ready = 1'b1;
      end
      c++;
    end
    ring_in_valid = 1'b0;
    check("bp_drained", 32'(rq.size()), 32'd0);
    idle(2);

    // Reset in the middle of a 4-flit packet to port 1
    ring_flit(16'h0006, 1'b1, 1'b0);
    ring_flit(16'hC001, 1'b0, 1'b0);
    idle(1);
    rst = 1'b0;
    idle(1);
    check("midrst_ring_out_valid", 32'(ring_out_valid), 32'd0);
    check("midrst_local_out_valid", 32'(local_out_valid), 32'd0);
    check("midrst_ring_in_ready", 32'(ring_in_ready), 32'd0);
    check("midrst_local_in_ready", 32'(local_in_ready), 32'd0);
    rst = 1'b1;
    m_routed = 1'b0;
    ring_flit(16'hC002, 1'b0, 1'b0);
    ring_flit(16'hC003, 1'b0, 1'b1);
    ring_flit(16'h0007, 1'b1, 1'b0);
    check("post_rst_route_port2", 32'(local_out_valid), 32'b100);
    ring_flit(16'hD001, 1'b0, 1'b1);
    idle(2);

    // Arbitration after reset: local 0, local 2 and FORWARD, three 2-flit packets each
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    m_routed = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rq.push_back({2'b10, 16'h1000 + 16'(r * 16)});
      rq.push_back({2'b01, 16'h1001 + 16'(r * 16)});
      rq.push_back({2'b10, 16'h3000 + 16'(r * 16)});
      rq.push_back({2'b01, 16'h3001 + 16'(r * 16)});
      rq.push_back({2'b10, 16'h2200 + 16'(r * 16)});
      rq.push_back({2'b01, 16'h2201 + 16'(r * 16)});
    end
    lp0 = 0; lp2 = 0; fptr = 0; c = 0;
    while ((lp0 < 6 || lp2 < 6 || fptr < 6 || rq.size() != 0) && c < 200) begin
      local_in_valid = {lp2 < 6, 1'b0, lp0 < 6};
      local_in_first = {lp2 % 2 == 0, 1'b0, lp0 % 2 == 0};
      local_in_last  = {lp2 % 2 == 1, 1'b0, lp0 % 2 == 1};
      local_in_data  = {16'h3000 + 16'((lp2 / 2) * 16 + lp2 % 2), 16'h0000,
                        16'h1000 + 16'((lp0 / 2) * 16 + lp0 % 2)};
      ring_in_valid  = (fptr < 6);
      ring_in_first  = (fptr % 2 == 0);
      ring_in_last   = (fptr % 2 == 1);
      ring_in_data   = 16'h2200 + 16'((fptr / 2) * 16 + fptr % 2);
      @(negedge clk);
      a0  = local_in_valid[0] && local_in_ready[0];
      a2  = local_in_valid[2] && local_in_ready[2];
      acc = ring_in_valid && ring_in_ready;
      @(posedge clk); #1;
      if (a0)  lp0++;
      if (a2)  lp2++;
      if (acc) fptr++;
      c++;
    end
    local_in_valid = '0;
    ring_in_valid  = 1'b0;
    check("arb_all_accepted", 32'(lp0 + lp2 + fptr), 32'd18);
    check("arb_rq_drained", 32'(rq.size()), 32'd0);

    idle(3);
    check("final_local_drained", 32'(lq0.size() + lq1.size() + lq2.size()), 32'd0);
    check("final_ring_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
